jt10_adpcm_rom_arb: RTL and testbench
=====================================

# jt10_adpcm_rom_arb

Shares the single ADPCM sample ROM port between the ADPCM-A channel address counter and the ADPCM-B decoder. It accepts one-cycle fetch strobes with nibble addresses from each requester and arbitrates them onto the ROM port. A has fixed priority with a starvation guard for B. It returns the selected nibble with a one-cycle `ok` pulse. The block sits between the ADPCM address counters and the top-level ROM/SDRAM interface.

## Interface
- `MAX_WAIT`, 15: cycles B may wait while pending before it overrides A's priority; range 1–255.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `a_strobe` in 1: ADPCM-A fetch request, one-cycle pulse.
- `a_addr` in 24: ADPCM-A byte address, `{bank, addr}`; sampled with `a_strobe`.
- `a_sel` in 1: ADPCM-A nibble select. 0 selects `[7:4]`; 1 selects `[3:0]`.
- `b_strobe`, `b_addr`, `b_sel` in 1/24/1: same as the A signals, for ADPCM-B.
- `a_data`, `b_data` out 4: returned nibble, held until the next completion for that requester.
- `a_ok`, `b_ok` out 1: one-cycle completion pulse.
- `err` out 1: sticky flag, set when a strobe arrives while that requester already has a transaction outstanding.
- `rom_addr` out 24: ROM byte address.
- `rom_cs` out 1: ROM request, held until the access completes.
- `rom_data` in 8: ROM read data.
- `rom_ok` in 1: ROM data valid.

## Operation
- Each requester has a pending register: valid bit, address and sel.
  - A strobe with no outstanding transaction loads the register.
  - A strobe while pending or granted is dropped and sets `err`.
- FSM states: IDLE, WAIT_A, WAIT_B.
  - **IDLE:** if any request is pending, grant it, register `rom_addr`, set `rom_cs` = 1, and move to WAIT_x. The grant may be made in the same edge that the strobe is captured, if no cache hit applies.
  - **Arbitration:** A wins over B unless `b_wait` == `MAX_WAIT`; in that case B wins.
  - **WAIT_x:** `rom_ok` is ignored during the first cycle of `rom_cs` (stale-ok guard). On a later edge with `rom_ok` = 1:
    - latch the nibble selected by the pending `sel` into `x_data`;
    - pulse `x_ok`;
    - clear that requester's pending bit;
    - clear `rom_cs`;
    - return to IDLE.
- `b_wait` is an 8-bit counter:
  - increments each cycle B is pending and not granted;
  - saturates at `MAX_WAIT`;
  - clears when B is granted.
- `rom_addr` stays stable for the whole time `rom_cs` is high.
- `rom_cs` deasserts for at least one cycle between accesses.
- Both strobes arriving in the same cycle are both captured. Service order follows the arbitration rule.
- A and B completions never coincide. At most one `ok` pulses per cycle.

## Timing
- Reset values:
  - `a_data`, `b_data` = 0; `a_ok`, `b_ok` = 0; `err` = 0;
  - `rom_addr` = 0; `rom_cs` = 0;
  - state IDLE, pending cleared, `b_wait` = 0, cache invalid.
- Reset mid-access: `rom_cs` drops immediately and no `ok` is issued. A `rom_ok` arriving after reset is ignored.
- Miss latency, with strobe captured at edge N and the ROM responding as early as allowed:
  - `rom_cs` high after edge N;
  - `rom_ok` first honoured at edge N+2;
  - `ok` visible after edge N+2.
  - This is a minimum of 2 cycles from capture.
- A request blocked behind the other requester waits for that transaction to complete, plus one IDLE cycle.

## Configuration
- **`JT10_ROMARB_CACHE_EN` defined:** each requester keeps a one-byte cache holding its last fetched address and byte, with a valid bit.
  - A strobe whose `addr` equals the cached address returns the nibble from the cache.
  - `ok` pulses on the edge after capture, with no `rom_cs`. The access takes no ROM cycle and does not affect `b_wait`.
  - Caches are invalidated at reset.
- **Undefined:** every strobe goes to the ROM. No cache storage is built.

## Test plan
- **Single A fetch, `sel` = 0:** `a_addr` = 0x012345, ROM returns 0xA7 with `rom_ok` 3 cycles after `rom_cs` → `rom_addr` = 0x012345, `a_data` = 0xA, one `a_ok` pulse, `rom_cs` low after completion.
- **Simultaneous strobes:** A at 0x000010 with `sel` = 1, B at 0x100000; ROM returns 0x5C then 0x3E → A served first with `a_data` = 0xC, then B with `b_data` = 0x3 (`sel` = 0). No overlapping `ok` pulses.
- **Starvation:** `MAX_WAIT` = 4; a B request is pending while A is re-strobed back to back for 20 cycles, with the ROM answering every 3 cycles → B is granted once `b_wait` reaches 4, before the next A grant.
- **Stale ok:** `rom_ok` held at 1 continuously → data is latched on the second `rom_cs` cycle, not the first.
- **Protocol error and reset:**
  - A second `a_strobe` while A is in flight → `err` = 1, the in-flight transaction completes normally, and `err` stays set.
  - `rst` asserted during WAIT_B → `rom_cs` = 0, `err` = 0, and no `b_ok` is issued.
- **Cache, with `JT10_ROMARB_CACHE_EN` defined:** two A strobes to 0x000200, first with `sel` 0 then with `sel` 1; ROM byte 0x9B → first result 0x9 via ROM, second result 0xB one cycle after the strobe with no `rom_cs`. Without the macro, both strobes access the ROM.

Source files
------------

// File: rtl/jt10_adpcm_rom_arb.sv
// Shares one ADPCM sample ROM port between the ADPCM-A and ADPCM-B nibble fetchers.
// Define JT10_ROMARB_CACHE_EN to add a one-byte per-requester cache that answers address hits without the ROM.
module jt10_adpcm_rom_arb #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_strobe,
  input  logic [23:0] a_addr,
  input  logic        a_sel,
  input  logic        b_strobe,
  input  logic [23:0] b_addr,
  input  logic        b_sel,
  output logic [3:0]  a_data,
  output logic [3:0]  b_data,
  output logic        a_ok,
  output logic        b_ok,
  output logic        err,
  output logic [23:0] rom_addr,
  output logic        rom_cs,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok
);

  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic        first_q, first_d;
  logic        rom_cs_q, rom_cs_d;
  logic [23:0] rom_addr_q, rom_addr_d;
  logic        a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic [23:0] a_paddr_q, a_paddr_d, b_paddr_q, b_paddr_d;
  logic        a_psel_q, a_psel_d, b_psel_q, b_psel_d;
  logic [3:0]  a_data_q, a_data_d, b_data_q, b_data_d;
  logic        a_ok_q, a_ok_d, b_ok_q, b_ok_d;
  logic        err_q, err_d;
  logic [7:0]  b_wait_q, b_wait_d;

  logic        a_hit, b_hit, a_new, b_new, a_req, b_req, a_done, b_done;
  logic [23:0] a_req_addr, b_req_addr;

`ifdef JT10_ROMARB_CACHE_EN
  logic        a_cval_q, a_cval_d, b_cval_q, b_cval_d;
  logic [23:0] a_caddr_q, a_caddr_d, b_caddr_q, b_caddr_d;
  logic [7:0]  a_cbyte_q, a_cbyte_d, b_cbyte_q, b_cbyte_d;
`endif

  function automatic logic [3:0] nibble(input logic [7:0] val, input logic sel);
    return sel ? val[3:0] : val[7:4];
  endfunction

  always_comb begin
    state_d    = state_q;
    first_d    = 1'b0;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    a_pend_d   = a_pend_q;
    a_paddr_d  = a_paddr_q;
    a_psel_d   = a_psel_q;
    b_pend_d   = b_pend_q;
    b_paddr_d  = b_paddr_q;
    b_psel_d   = b_psel_q;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    a_ok_d     = 1'b0;
    b_ok_d     = 1'b0;
    err_d      = err_q;
    b_wait_d   = b_wait_q;

    a_done = (state_q == WAIT_A) && !first_q && rom_ok;
    b_done = (state_q == WAIT_B) && !first_q && rom_ok;

`ifdef JT10_ROMARB_CACHE_EN
    // A hit that would pulse ok alongside another completion falls back to a ROM fetch.
    a_hit = a_strobe && !a_pend_q && a_cval_q && (a_caddr_q == a_addr) && !b_done;
    b_hit = b_strobe && !b_pend_q && b_cval_q && (b_caddr_q == b_addr) && !a_done && !a_hit;
`else
    a_hit = 1'b0;
    b_hit = 1'b0;
`endif

    a_new = a_strobe && !a_pend_q && !a_hit;
    b_new = b_strobe && !b_pend_q && !b_hit;
    if ((a_strobe && a_pend_q) || (b_strobe && b_pend_q)) err_d = 1'b1;

    if (a_new) begin
      a_pend_d  = 1'b1;
      a_paddr_d = a_addr;
      a_psel_d  = a_sel;
    end
    if (b_new) begin
      b_pend_d  = 1'b1;
      b_paddr_d = b_addr;
      b_psel_d  = b_sel;
    end

    // A capture and its grant can share one edge, so arbitrate on pending-or-arriving.
    a_req      = a_pend_q || a_new;
    b_req      = b_pend_q || b_new;
    a_req_addr = a_pend_q ? a_paddr_q : a_addr;
    b_req_addr = b_pend_q ? b_paddr_q : b_addr;

    if (b_pend_q && (state_q != WAIT_B) && (b_wait_q != MaxWait)) b_wait_d = b_wait_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (a_req && !(b_req && (b_wait_q == MaxWait))) begin
          rom_addr_d = a_req_addr;
          rom_cs_d   = 1'b1;
          first_d    = 1'b1;
          state_d    = WAIT_A;
        end else if (b_req) begin
          rom_addr_d = b_req_addr;
          rom_cs_d   = 1'b1;
          first_d    = 1'b1;
          b_wait_d   = '0;
          state_d    = WAIT_B;
        end
      end
      WAIT_A: begin
        if (a_done) begin
          a_data_d = nibble(rom_data, a_psel_q);
          a_ok_d   = 1'b1;
          a_pend_d = 1'b0;
          rom_cs_d = 1'b0;
          state_d  = IDLE;
        end
      end
      WAIT_B: begin
        if (b_done) begin
          b_data_d = nibble(rom_data, b_psel_q);
          b_ok_d   = 1'b1;
          b_pend_d = 1'b0;
          rom_cs_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef JT10_ROMARB_CACHE_EN
    a_cval_d  = a_cval_q;
    a_caddr_d = a_caddr_q;
    a_cbyte_d = a_cbyte_q;
    b_cval_d  = b_cval_q;
    b_caddr_d = b_caddr_q;
    b_cbyte_d = b_cbyte_q;
    if (a_hit) begin
      a_data_d = nibble(a_cbyte_q, a_sel);
      a_ok_d   = 1'b1;
    end
    if (b_hit) begin
      b_data_d = nibble(b_cbyte_q, b_sel);
      b_ok_d   = 1'b1;
    end
    if (a_done) begin
      a_cval_d  = 1'b1;
      a_caddr_d = rom_addr_q;
      a_cbyte_d = rom_data;
    end
    if (b_done) begin
      b_cval_d  = 1'b1;
      b_caddr_d = rom_addr_q;
      b_cbyte_d = rom_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      a_pend_q   <= 1'b0;
      a_paddr_q  <= '0;
      a_psel_q   <= 1'b0;
      b_pend_q   <= 1'b0;
      b_paddr_q  <= '0;
      b_psel_q   <= 1'b0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      a_ok_q     <= 1'b0;
      b_ok_q     <= 1'b0;
      err_q      <= 1'b0;
      b_wait_q   <= '0;
`ifdef JT10_ROMARB_CACHE_EN
      a_cval_q   <= 1'b0;
      a_caddr_q  <= '0;
      a_cbyte_q  <= '0;
      b_cval_q   <= 1'b0;
      b_caddr_q  <= '0;
      b_cbyte_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      a_pend_q   <= a_pend_d;
      a_paddr_q  <= a_paddr_d;
      a_psel_q   <= a_psel_d;
      b_pend_q   <= b_pend_d;
      b_paddr_q  <= b_paddr_d;
      b_psel_q   <= b_psel_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      a_ok_q     <= a_ok_d;
      b_ok_q     <= b_ok_d;
      err_q      <= err_d;
      b_wait_q   <= b_wait_d;
`ifdef JT10_ROMARB_CACHE_EN
      a_cval_q   <= a_cval_d;
      a_caddr_q  <= a_caddr_d;
      a_cbyte_q  <= a_cbyte_d;
      b_cval_q   <= b_cval_d;
      b_caddr_q  <= b_caddr_d;
      b_cbyte_q  <= b_cbyte_d;
`endif
    end
  end

  assign a_data   = a_data_q;
  assign b_data   = b_data_q;
  assign a_ok     = a_ok_q;
  assign b_ok     = b_ok_q;
  assign err      = err_q;
  assign rom_addr = rom_addr_q;
  assign rom_cs   = rom_cs_q;

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// Directed bench for jt10_adpcm_rom_arb with a simple ROM responder model.
module tb_jt10_adpcm_rom_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_strobe = 1'b0, b_strobe = 1'b0;
  logic [23:0] a_addr = '0, b_addr = '0;
  logic        a_sel = 1'b0, b_sel = 1'b0;
  logic [3:0]  a_data, b_data;
  logic        a_ok, b_ok, err;
  logic [23:0] rom_addr;
  logic        rom_cs;
  logic [7:0]  rom_data = '0;
  logic        rom_ok = 1'b0;

  int          n_vec = 0;
  int          n_err = 0;
  int          rom_lat = 3;
  logic        rom_always = 1'b0;
  int          overlap = 0;
  int          addr_moves = 0;
  logic [23:0] grants[$];

  jt10_adpcm_rom_arb #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_strobe(a_strobe), .a_addr(a_addr), .a_sel(a_sel),
    .b_strobe(b_strobe), .b_addr(b_addr), .b_sel(b_sel),
    .a_data(a_data), .b_data(b_data), .a_ok(a_ok), .b_ok(b_ok), .err(err),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [23:0] addr);
    case (addr)
      24'h012345: return 8'hA7;
      24'h000010: return 8'h5C;
      24'h100000: return 8'h3E;
      24'h000200: return 8'h9B;
      default:    return addr[7:0] ^ 8'h5A;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ok(input string tag, input logic is_b, output int k);
    logic seen;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      seen = is_b ? b_ok : a_ok;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic strobe_a(input logic [23:0] addr, input logic sel);
    a_strobe = 1'b1; a_addr = addr; a_sel = sel;
    @(negedge clk);
    a_strobe = 1'b0;
  endtask

  task automatic strobe_b(input logic [23:0] addr, input logic sel);
    b_strobe = 1'b1; b_addr = addr; b_sel = sel;
    @(negedge clk);
    b_strobe = 1'b0;
  endtask

  // ROM model: valid data after rom_lat cycles of rom_cs, or ok stuck high in rom_always mode
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rom_cs) cnt++; else cnt = 0;
      if (rom_always) begin
        rom_ok   = 1'b1;
        rom_data = (rom_cs && cnt >= 2) ? rom_val(rom_addr) : 8'hFF;
      end else begin
        rom_ok   = rom_cs && (cnt >= rom_lat);
        rom_data = rom_ok ? rom_val(rom_addr) : 8'h00;
      end
    end
  end

  initial begin
    logic        prev_cs;
    logic [23:0] held;
    prev_cs = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (a_ok && b_ok) overlap++;
      if (rom_cs && !prev_cs) begin
        grants.push_back(rom_addr);
        held = rom_addr;
      end else if (rom_cs && rom_addr !== held) begin
        addr_moves++;
      end
      prev_cs = rom_cs;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    int k;
    int extra;
    int ngr;

    @(negedge clk);
    check("rst_a_data", 32'(a_data), 32'h0);
    check("rst_b_data", 32'(b_data), 32'h0);
    check("rst_a_ok", 32'(a_ok), 32'h0);
    check("rst_b_ok", 32'(b_ok), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_rom_cs", 32'(rom_cs), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single A fetch, nibble [7:4]
    strobe_a(24'h012345, 1'b0);
    check("t1_cs", 32'(rom_cs), 32'h1);
    check("t1_addr", 32'(rom_addr), 32'h012345);
    wait_ok("t1", 1'b0, k);
    check("t1_lat", 32'(k), 32'd3);
    check("t1_data", 32'(a_data), 32'hA);
    check("t1_cs_off", 32'(rom_cs), 32'h0);
    @(negedge clk);
    check("t1_pulse", 32'(a_ok), 32'h0);
    check("t1_hold", 32'(a_data), 32'hA);

    // simultaneous strobes: A first, then B after one idle cycle
    a_strobe = 1'b1; a_addr = 24'h000010; a_sel = 1'b1;
    b_strobe = 1'b1; b_addr = 24'h100000; b_sel = 1'b0;
    @(negedge clk);
    a_strobe = 1'b0; b_strobe = 1'b0;
    check("t2_addr_a", 32'(rom_addr), 32'h000010);
    wait_ok("t2a", 1'b0, k);
    check("t2_lat_a", 32'(k), 32'd3);
    check("t2_data_a", 32'(a_data), 32'hC);
    check("t2_b_idle", 32'(b_ok), 32'h0);
    @(negedge clk);
    check("t2_cs_b", 32'(rom_cs), 32'h1);
    check("t2_addr_b", 32'(rom_addr), 32'h100000);
    wait_ok("t2b", 1'b1, k);
    check("t2_lat_b", 32'(k), 32'd3);
    check("t2_data_b", 32'(b_data), 32'h3);

    // starvation guard with MAX_WAIT=4: grants A1, A2, B1, A3
    ngr = grants.size();
    a_strobe = 1'b1; a_addr = 24'h000300; a_sel = 1'b0;
    b_strobe = 1'b1; b_addr = 24'h100044; b_sel = 1'b1;
    @(negedge clk);
    a_strobe = 1'b0; b_strobe = 1'b0;
    wait_ok("t3a1", 1'b0, k);
    check("t3_lat_a1", 32'(k), 32'd3);
    strobe_a(24'h000301, 1'b0);
    wait_ok("t3a2", 1'b0, k);
    check("t3_lat_a2", 32'(k), 32'd3);
    strobe_a(24'h000302, 1'b1);
    check("t3_b_wins", 32'(rom_addr), 32'h100044);
    wait_ok("t3b", 1'b1, k);
    check("t3_lat_b", 32'(k), 32'd3);
    check("t3_data_b", 32'(b_data), 32'hE);
    wait_ok("t3a3", 1'b0, k);
    check("t3_lat_a3", 32'(k), 32'd4);
    check("t3_data_a3", 32'(a_data), 32'h8);
    check("t3_ngrants", 32'(grants.size() - ngr), 32'd4);
    if (grants.size() - ngr == 4) begin
      check("t3_g0", 32'(grants[ngr]), 32'h000300);
      check("t3_g1", 32'(grants[ngr + 1]), 32'h000301);
      check("t3_g2", 32'(grants[ngr + 2]), 32'h100044);
      check("t3_g3", 32'(grants[ngr + 3]), 32'h000302);
    end
    check("t3_err", 32'(err), 32'h0);

    // stale ok: rom_ok stuck high, only the second rom_cs cycle counts
    rom_always = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_idle_cs", 32'(rom_cs), 32'h0);
    check("t4_idle_ok", 32'(a_ok | b_ok), 32'h0);
    strobe_a(24'h000010, 1'b0);
    check("t4_first", 32'(a_ok), 32'h0);
    wait_ok("t4", 1'b0, k);
    rom_always = 1'b0;
    check("t4_lat", 32'(k), 32'd2);
    check("t4_data", 32'(a_data), 32'h5);
    repeat (2) @(negedge clk);

    // protocol error: second A strobe while in flight is dropped
    strobe_a(24'h012345, 1'b1);
    strobe_a(24'h000010, 1'b0);
    check("t5_err", 32'(err), 32'h1);
    check("t5_addr", 32'(rom_addr), 32'h012345);
    wait_ok("t5", 1'b0, k);
    check("t5_lat", 32'(k), 32'd2);
    check("t5_data", 32'(a_data), 32'h7);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ok) extra++;
    end
    check("t5_dropped", 32'(extra), 32'd0);
    check("t5_cs", 32'(rom_cs), 32'h0);
    check("t5_err_sticky", 32'(err), 32'h1);

    // reset during WAIT_B
    strobe_b(24'h100000, 1'b0);
    check("t6_cs_pre", 32'(rom_cs), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_cs", 32'(rom_cs), 32'h0);
    check("t6_err", 32'(err), 32'h0);
    check("t6_b_data", 32'(b_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    rom_always = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (b_ok || rom_cs) extra++;
    end
    rom_always = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (b_ok || rom_cs) extra++;
    end
    check("t6_quiet", 32'(extra), 32'd0);

    // cache: repeat fetch of the same byte
    strobe_a(24'h000200, 1'b0);
    wait_ok("t7m", 1'b0, k);
    check("t7_data_miss", 32'(a_data), 32'h9);
    ngr = grants.size();
    strobe_a(24'h000200, 1'b1);
`ifdef JT10_ROMARB_CACHE_EN
    check("t7_hit_ok", 32'(a_ok), 32'h1);
    check("t7_hit_cs", 32'(rom_cs), 32'h0);
    check("t7_hit_data", 32'(a_data), 32'hB);
    @(negedge clk);
    check("t7_hit_pulse", 32'(a_ok), 32'h0);
    check("t7_rom_used", 32'(grants.size() - ngr), 32'd0);
`else
    check("t7_cs", 32'(rom_cs), 32'h1);
    wait_ok("t7r", 1'b0, k);
    check("t7_lat", 32'(k), 32'd3);
    check("t7_data", 32'(a_data), 32'hB);
    check("t7_rom_used", 32'(grants.size() - ngr), 32'd1);
`endif

    repeat (2) @(negedge clk);
    #1;
    check("no_overlap", 32'(overlap), 32'd0);
    check("addr_stable", 32'(addr_moves), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
